// File: rtl/slot_rom_arbiter_if.sv
// CPU-side bus and card select lines of the slot ROM arbiter.
// The master modport belongs to the CPU/bus side and the slave modport to the arbiter.
interface slot_rom_arbiter_if;
  logic        BUS_CE;
  logic [15:0] ADDRESS;
  logic        RW_N;
  logic [6:0]  IO_SELECT_N;
  logic [6:0]  DEVICE_SELECT_N;
  logic [6:0]  IO_STROBE_N;
  logic [2:0]  C8_OWNER;
  logic        INT_ROM_SEL;
  logic        INTCXROM;
  logic        SLOTC3ROM;
  logic        INTC8ROM;
  logic        STATUS_OE;
  logic        STATUS_D7;

  modport master (
    output BUS_CE, ADDRESS, RW_N,
    input  IO_SELECT_N, DEVICE_SELECT_N, IO_STROBE_N, C8_OWNER, INT_ROM_SEL,
           INTCXROM, SLOTC3ROM, INTC8ROM, STATUS_OE, STATUS_D7
  );

  modport slave (
    input  BUS_CE, ADDRESS, RW_N,
    output IO_SELECT_N, DEVICE_SELECT_N, IO_STROBE_N, C8_OWNER, INT_ROM_SEL,
           INTCXROM, SLOTC3ROM, INTC8ROM, STATUS_OE, STATUS_D7
  );
endinterface

// File: rtl/slot_rom_arbiter.sv
// Apple IIe slot ROM arbiter: decodes $Cn00/$C800/$C0nx selects, tracks the $C800
// window owner and holds the INTCXROM / SLOTC3ROM / INTC8ROM soft switches.
module slot_rom_arbiter #(
  parameter logic [6:0] SLOT_MASK = 7'b0000010,
  parameter bit         IIE_MODE  = 1'b1
) (
  input logic          CLK_14M,
  input logic          RESET,
  slot_rom_arbiter_if.slave bus
);

  function automatic logic [6:0] slot_sel_n(input logic [2:0] slot);
    logic [6:0] sel;
    sel = 7'b1111111;
    if (slot != 3'd0) begin
      sel[slot - 3'd1] = 1'b0;
    end else begin
      sel = 7'b1111111;
    end
    return sel;
  endfunction

  function automatic logic slot_present(input logic [2:0] slot);
    logic [6:0] mask_v;
    logic       hit;
    mask_v = SLOT_MASK;
    if (slot != 3'd0) begin
      hit = mask_v[slot - 3'd1];
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  logic [2:0] owner_r, owner_s;
  logic       intcxrom_r, intcxrom_s;
  logic       slotc3rom_r, slotc3rom_s;
  logic       intc8rom_r, intc8rom_s;

  logic [2:0] cn_slot_s, dev_slot_s;
  logic       is_cn_s, is_c8_s, is_dev_s;
  logic [6:0] io_select_n_s, device_select_n_s, io_strobe_n_s;
  logic       int_rom_sel_s, status_oe_s, status_d7_s;

  // Address decode, select generation and next-state for owner and soft switches
  always_comb begin
    owner_s           = owner_r;
    intcxrom_s        = intcxrom_r;
    slotc3rom_s       = slotc3rom_r;
    intc8rom_s        = intc8rom_r;
    io_select_n_s     = 7'b1111111;
    device_select_n_s = 7'b1111111;
    io_strobe_n_s     = 7'b1111111;
    int_rom_sel_s     = 1'b0;
    status_oe_s       = 1'b0;
    status_d7_s       = 1'b0;

    cn_slot_s  = bus.ADDRESS[10:8];
    dev_slot_s = bus.ADDRESS[6:4];
    is_cn_s    = (bus.ADDRESS[15:11] == 5'b11000) && (cn_slot_s != 3'd0);
    is_c8_s    = (bus.ADDRESS[15:11] == 5'b11001);
    is_dev_s   = (bus.ADDRESS[15:8] == 8'hC0) && bus.ADDRESS[7] && (dev_slot_s != 3'd0);

    if (is_dev_s && slot_present(dev_slot_s)) begin
      device_select_n_s = slot_sel_n(dev_slot_s);
    end else begin
      device_select_n_s = 7'b1111111;
    end

    if (is_cn_s) begin
      if (intcxrom_r) begin
        int_rom_sel_s = 1'b1;
      end else if ((cn_slot_s == 3'd3) && !slotc3rom_r) begin
        // Internal $C3 ROM claims the $C800 window for itself
        int_rom_sel_s = 1'b1;
        if (bus.BUS_CE) begin
          intc8rom_s = 1'b1;
        end else begin
          intc8rom_s = intc8rom_r;
        end
      end else if (slot_present(cn_slot_s)) begin
        io_select_n_s = slot_sel_n(cn_slot_s);
        if (bus.BUS_CE) begin
          owner_s    = cn_slot_s;
          intc8rom_s = 1'b0;
        end else begin
          owner_s    = owner_r;
        end
      end else begin
        io_select_n_s = 7'b1111111;
      end
    end else if (is_c8_s) begin
      if (intcxrom_r || intc8rom_r) begin
        int_rom_sel_s = 1'b1;
      end else begin
        io_strobe_n_s = slot_sel_n(owner_r);
      end
      // $CFFF strobes the current owner in this cycle, then releases the window
      if (bus.BUS_CE && (bus.ADDRESS[10:0] == 11'h7FF)) begin
        owner_s    = 3'd0;
        intc8rom_s = 1'b0;
      end else begin
        owner_s    = owner_r;
      end
    end else begin
      if (IIE_MODE && bus.BUS_CE && !bus.RW_N) begin
        case (bus.ADDRESS)
          16'hC006: intcxrom_s  = 1'b0;
          16'hC007: intcxrom_s  = 1'b1;
          16'hC00A: slotc3rom_s = 1'b0;
          16'hC00B: slotc3rom_s = 1'b1;
          default:  intcxrom_s  = intcxrom_r;
        endcase
      end else begin
        intcxrom_s = intcxrom_r;
      end
      if (IIE_MODE && bus.RW_N && ((bus.ADDRESS == 16'hC015) || (bus.ADDRESS == 16'hC017))) begin
        status_oe_s = 1'b1;
        status_d7_s = bus.ADDRESS[1] ? slotc3rom_r : intcxrom_r;
      end else begin
        status_oe_s = 1'b0;
      end
    end

    // Hold every card deselected while reset is asserted
    if (RESET) begin
      io_select_n_s     = 7'b1111111;
      device_select_n_s = 7'b1111111;
      io_strobe_n_s     = 7'b1111111;
      int_rom_sel_s     = 1'b0;
      status_oe_s       = 1'b0;
      status_d7_s       = 1'b0;
    end else begin
      status_d7_s       = status_d7_s;
    end
  end

  // Window owner and soft switch registers
  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      owner_r     <= 3'd0;
      intcxrom_r  <= 1'b0;
      slotc3rom_r <= 1'b0;
      intc8rom_r  <= 1'b0;
    end else begin
      owner_r     <= owner_s;
      intcxrom_r  <= intcxrom_s;
      slotc3rom_r <= slotc3rom_s;
      intc8rom_r  <= intc8rom_s;
    end
  end

  assign bus.IO_SELECT_N     = io_select_n_s;
  assign bus.DEVICE_SELECT_N = device_select_n_s;
  assign bus.IO_STROBE_N     = io_strobe_n_s;
  assign bus.INT_ROM_SEL     = int_rom_sel_s;
  assign bus.STATUS_OE       = status_oe_s;
  assign bus.STATUS_D7       = status_d7_s;
  assign bus.C8_OWNER        = owner_r;
  assign bus.INTCXROM        = intcxrom_r;
  assign bus.SLOTC3ROM       = slotc3rom_r;
  assign bus.INTC8ROM        = intc8rom_r;

endmodule

// File: tb/tb_slot_rom_arbiter.sv
// Directed bench for slot_rom_arbiter with cards in slots 2 and 7.
// Each task drives one scenario and compares against hand-computed values.
module tb_slot_rom_arbiter;
  logic CLK_14M;
  logic RESET;
  int   errors;
  int   checks;

  slot_rom_arbiter_if bus_if ();

  slot_rom_arbiter #(
    .SLOT_MASK (7'b1000010),
    .IIE_MODE  (1'b1)
  ) dut (
    .CLK_14M (CLK_14M),
    .RESET   (RESET),
    .bus     (bus_if)
  );

  initial CLK_14M = 1'b0;
  always #5 CLK_14M = ~CLK_14M;

  task automatic drive_cycle(input logic [15:0] a, input logic rw);
    @(negedge CLK_14M);
    bus_if.ADDRESS = a;
    bus_if.RW_N    = rw;
    bus_if.BUS_CE  = 1'b1;
    #1;
  endtask

  task automatic end_cycle();
    @(posedge CLK_14M);
    #1;
    bus_if.BUS_CE  = 1'b0;
    bus_if.ADDRESS = 16'h0000;
    bus_if.RW_N    = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge CLK_14M);
    RESET = 1'b1;
    bus_if.ADDRESS = 16'hC205;
    bus_if.BUS_CE  = 1'b1;
    @(posedge CLK_14M);
    #1;
    checks++; if (bus_if.IO_SELECT_N !== 7'b1111111) begin errors++; $display("FAIL reset_iosel: got %b want 1111111", bus_if.IO_SELECT_N); end
    checks++; if (bus_if.C8_OWNER !== 3'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", bus_if.C8_OWNER); end
    checks++; if ({bus_if.INTCXROM, bus_if.SLOTC3ROM, bus_if.INTC8ROM} !== 3'b000) begin errors++; $display("FAIL reset_switches: got %b want 000", {bus_if.INTCXROM, bus_if.SLOTC3ROM, bus_if.INTC8ROM}); end
    checks++; if (bus_if.STATUS_OE !== 1'b0) begin errors++; $display("FAIL reset_status_oe: got %b want 0", bus_if.STATUS_OE); end
    @(negedge CLK_14M);
    RESET = 1'b0;
    bus_if.BUS_CE  = 1'b0;
    bus_if.ADDRESS = 16'h0000;
    checks++; if (bus_if.C8_OWNER !== 3'd0) begin errors++; $display("FAIL reset_owner_after: got %0d want 0", bus_if.C8_OWNER); end
  endtask

  task automatic test_claim();
    drive_cycle(16'hC205, 1'b1);
    checks++; if (bus_if.IO_SELECT_N !== 7'b1111101) begin errors++; $display("FAIL claim_iosel: got %b want 1111101", bus_if.IO_SELECT_N); end
    checks++; if (bus_if.INT_ROM_SEL !== 1'b0) begin errors++; $display("FAIL claim_introm: got %b want 0", bus_if.INT_ROM_SEL); end
    end_cycle();
    checks++; if (bus_if.C8_OWNER !== 3'd2) begin errors++; $display("FAIL claim_owner: got %0d want 2", bus_if.C8_OWNER); end
    drive_cycle(16'hC900, 1'b1);
    checks++; if (bus_if.IO_STROBE_N !== 7'b1111101) begin errors++; $display("FAIL claim_strobe: got %b want 1111101", bus_if.IO_STROBE_N); end
    end_cycle();
  endtask

  task automatic test_release();
    drive_cycle(16'hCFFF, 1'b1);
    checks++; if (bus_if.IO_STROBE_N !== 7'b1111101) begin errors++; $display("FAIL release_own_strobe: got %b want 1111101", bus_if.IO_STROBE_N); end
    end_cycle();
    checks++; if (bus_if.C8_OWNER !== 3'd0) begin errors++; $display("FAIL release_owner: got %0d want 0", bus_if.C8_OWNER); end
    drive_cycle(16'hC900, 1'b1);
    checks++; if (bus_if.IO_STROBE_N !== 7'b1111111) begin errors++; $display("FAIL release_no_strobe: got %b want 1111111", bus_if.IO_STROBE_N); end
    checks++; if (bus_if.INT_ROM_SEL !== 1'b0) begin errors++; $display("FAIL release_introm: got %b want 0", bus_if.INT_ROM_SEL); end
    end_cycle();
  endtask

  task automatic test_intcxrom();
    drive_cycle(16'hC205, 1'b1);
    end_cycle();
    drive_cycle(16'hC007, 1'b0);
    end_cycle();
    checks++; if (bus_if.INTCXROM !== 1'b1) begin errors++; $display("FAIL cx_set: got %b want 1", bus_if.INTCXROM); end
    drive_cycle(16'hC205, 1'b1);
    checks++; if ({bus_if.INT_ROM_SEL, bus_if.IO_SELECT_N} !== 8'b1_1111111) begin errors++; $display("FAIL cx_cn: got %b want 11111111", {bus_if.INT_ROM_SEL, bus_if.IO_SELECT_N}); end
    end_cycle();
    checks++; if (bus_if.C8_OWNER !== 3'd2) begin errors++; $display("FAIL cx_owner_kept: got %0d want 2", bus_if.C8_OWNER); end
    drive_cycle(16'hC900, 1'b1);
    checks++; if ({bus_if.INT_ROM_SEL, bus_if.IO_STROBE_N} !== 8'b1_1111111) begin errors++; $display("FAIL cx_c8: got %b want 11111111", {bus_if.INT_ROM_SEL, bus_if.IO_STROBE_N}); end
    end_cycle();
    drive_cycle(16'hC015, 1'b1);
    checks++; if ({bus_if.STATUS_OE, bus_if.STATUS_D7} !== 2'b11) begin errors++; $display("FAIL cx_status_c015: got %b want 11", {bus_if.STATUS_OE, bus_if.STATUS_D7}); end
    end_cycle();
    drive_cycle(16'hC017, 1'b1);
    checks++; if ({bus_if.STATUS_OE, bus_if.STATUS_D7} !== 2'b10) begin errors++; $display("FAIL cx_status_c017: got %b want 10", {bus_if.STATUS_OE, bus_if.STATUS_D7}); end
    end_cycle();
    drive_cycle(16'hC006, 1'b1);
    end_cycle();
    checks++; if (bus_if.INTCXROM !== 1'b1) begin errors++; $display("FAIL cx_read_no_effect: got %b want 1", bus_if.INTCXROM); end
    drive_cycle(16'hC006, 1'b0);
    end_cycle();
    checks++; if (bus_if.INTCXROM !== 1'b0) begin errors++; $display("FAIL cx_clear: got %b want 0", bus_if.INTCXROM); end
    drive_cycle(16'hC900, 1'b1);
    checks++; if ({bus_if.INT_ROM_SEL, bus_if.IO_STROBE_N} !== 8'b0_1111101) begin errors++; $display("FAIL cx_strobe_back: got %b want 01111101", {bus_if.INT_ROM_SEL, bus_if.IO_STROBE_N}); end
    end_cycle();
  endtask

  task automatic test_slotc3();
    drive_cycle(16'hC300, 1'b1);
    checks++; if ({bus_if.INT_ROM_SEL, bus_if.IO_SELECT_N} !== 8'b1_1111111) begin errors++; $display("FAIL c3_internal: got %b want 11111111", {bus_if.INT_ROM_SEL, bus_if.IO_SELECT_N}); end
    end_cycle();
    checks++; if ({bus_if.INTC8ROM, bus_if.C8_OWNER} !== 4'b1_010) begin errors++; $display("FAIL c3_intc8_set: got %b want 1010", {bus_if.INTC8ROM, bus_if.C8_OWNER}); end
    drive_cycle(16'hC800, 1'b1);
    checks++; if ({bus_if.INT_ROM_SEL, bus_if.IO_STROBE_N} !== 8'b1_1111111) begin errors++; $display("FAIL c3_c800: got %b want 11111111", {bus_if.INT_ROM_SEL, bus_if.IO_STROBE_N}); end
    end_cycle();
    drive_cycle(16'hCFFF, 1'b0);
    end_cycle();
    checks++; if ({bus_if.INTC8ROM, bus_if.C8_OWNER} !== 4'b0_000) begin errors++; $display("FAIL c3_release: got %b want 0000", {bus_if.INTC8ROM, bus_if.C8_OWNER}); end
    drive_cycle(16'hC00B, 1'b0);
    end_cycle();
    drive_cycle(16'hC00A, 1'b1);
    end_cycle();
    checks++; if (bus_if.SLOTC3ROM !== 1'b1) begin errors++; $display("FAIL c3_slot_set: got %b want 1", bus_if.SLOTC3ROM); end
    drive_cycle(16'hC300, 1'b1);
    checks++; if ({bus_if.INT_ROM_SEL, bus_if.IO_SELECT_N} !== 8'b0_1111111) begin errors++; $display("FAIL c3_empty_slot: got %b want 01111111", {bus_if.INT_ROM_SEL, bus_if.IO_SELECT_N}); end
    end_cycle();
    checks++; if ({bus_if.INTC8ROM, bus_if.C8_OWNER} !== 4'b0_000) begin errors++; $display("FAIL c3_empty_state: got %b want 0000", {bus_if.INTC8ROM, bus_if.C8_OWNER}); end
    drive_cycle(16'hC00A, 1'b0);
    end_cycle();
    checks++; if (bus_if.SLOTC3ROM !== 1'b0) begin errors++; $display("FAIL c3_slot_clear: got %b want 0", bus_if.SLOTC3ROM); end
  endtask

  task automatic test_empty_slot();
    drive_cycle(16'hC205, 1'b1);
    end_cycle();
    drive_cycle(16'hC500, 1'b1);
    checks++; if ({bus_if.INT_ROM_SEL, bus_if.IO_SELECT_N} !== 8'b0_1111111) begin errors++; $display("FAIL empty_c500: got %b want 01111111", {bus_if.INT_ROM_SEL, bus_if.IO_SELECT_N}); end
    end_cycle();
    checks++; if (bus_if.C8_OWNER !== 3'd2) begin errors++; $display("FAIL empty_owner: got %0d want 2", bus_if.C8_OWNER); end
    drive_cycle(16'hC0AB, 1'b1);
    checks++; if (bus_if.DEVICE_SELECT_N !== 7'b1111101) begin errors++; $display("FAIL devsel_slot2: got %b want 1111101", bus_if.DEVICE_SELECT_N); end
    end_cycle();
    drive_cycle(16'hC0FB, 1'b0);
    checks++; if (bus_if.DEVICE_SELECT_N !== 7'b0111111) begin errors++; $display("FAIL devsel_slot7: got %b want 0111111", bus_if.DEVICE_SELECT_N); end
    end_cycle();
    drive_cycle(16'hC0CB, 1'b1);
    checks++; if (bus_if.DEVICE_SELECT_N !== 7'b1111111) begin errors++; $display("FAIL devsel_absent: got %b want 1111111", bus_if.DEVICE_SELECT_N); end
    end_cycle();
    drive_cycle(16'hC007, 1'b0);
    end_cycle();
    drive_cycle(16'hC0A0, 1'b1);
    checks++; if (bus_if.DEVICE_SELECT_N !== 7'b1111101) begin errors++; $display("FAIL devsel_cx_unmasked: got %b want 1111101", bus_if.DEVICE_SELECT_N); end
    end_cycle();
    drive_cycle(16'hC006, 1'b0);
    end_cycle();
  endtask

  task automatic test_back_to_back();
    drive_cycle(16'hC205, 1'b1);
    end_cycle();
    drive_cycle(16'hC700, 1'b1);
    checks++; if (bus_if.IO_SELECT_N !== 7'b0111111) begin errors++; $display("FAIL b2b_iosel7: got %b want 0111111", bus_if.IO_SELECT_N); end
    end_cycle();
    checks++; if (bus_if.C8_OWNER !== 3'd7) begin errors++; $display("FAIL b2b_owner: got %0d want 7", bus_if.C8_OWNER); end
    drive_cycle(16'hC800, 1'b1);
    checks++; if (bus_if.IO_STROBE_N !== 7'b0111111) begin errors++; $display("FAIL b2b_strobe: got %b want 0111111", bus_if.IO_STROBE_N); end
    end_cycle();
    @(negedge CLK_14M);
    bus_if.ADDRESS = 16'hC205;
    bus_if.BUS_CE  = 1'b0;
    #1;
    checks++; if (bus_if.IO_SELECT_N !== 7'b1111101) begin errors++; $display("FAIL nocе_iosel: got %b want 1111101", bus_if.IO_SELECT_N); end
    @(posedge CLK_14M);
    #1;
    checks++; if (bus_if.C8_OWNER !== 3'd7) begin errors++; $display("FAIL noce_owner: got %0d want 7", bus_if.C8_OWNER); end
    bus_if.ADDRESS = 16'h0000;
  endtask

  task automatic test_reset_midop();
    drive_cycle(16'hC205, 1'b1);
    end_cycle();
    drive_cycle(16'hC007, 1'b0);
    end_cycle();
    checks++; if ({bus_if.INTCXROM, bus_if.C8_OWNER} !== 4'b1_010) begin errors++; $display("FAIL midrst_pre: got %b want 1010", {bus_if.INTCXROM, bus_if.C8_OWNER}); end
    @(negedge CLK_14M);
    RESET = 1'b1;
    bus_if.ADDRESS = 16'hC900;
    @(posedge CLK_14M);
    #1;
    RESET = 1'b0;
    #1;
    checks++; if ({bus_if.INTCXROM, bus_if.SLOTC3ROM, bus_if.INTC8ROM, bus_if.C8_OWNER} !== 6'b000_000) begin errors++; $display("FAIL midrst_state: got %b want 000000", {bus_if.INTCXROM, bus_if.SLOTC3ROM, bus_if.INTC8ROM, bus_if.C8_OWNER}); end
    checks++; if ({bus_if.INT_ROM_SEL, bus_if.IO_STROBE_N} !== 8'b0_1111111) begin errors++; $display("FAIL midrst_selects: got %b want 01111111", {bus_if.INT_ROM_SEL, bus_if.IO_STROBE_N}); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RESET  = 1'b1;
    bus_if.BUS_CE  = 1'b0;
    bus_if.ADDRESS = 16'h0000;
    bus_if.RW_N    = 1'b1;
    repeat (2) @(posedge CLK_14M);
    test_reset();
    test_claim();
    test_release();
    test_intcxrom();
    test_slotc3();
    test_empty_slot();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
